// File: rtl/fib_breath_pkg.sv
// Shared types, period helper and the single Fibonacci step used by the
// breathing-LED scheduler's time-multiplexed add/sub unit.
package fib_breath_pkg;
  // Widest supported duty width plus one bit of carry headroom for the sum.
  localparam int FIB_W = 16;

  typedef enum logic {DIR_RISE = 1'b0, DIR_FALL = 1'b1} dir_e;

  typedef struct packed {
    logic [FIB_W-1:0] prev;
    logic [FIB_W-1:0] cur;
    dir_e             dir;
  } chan_state_t;

  function automatic int fib_period(input int cw);
    return 1 << cw;
  endfunction

  function automatic chan_state_t fib_step(input chan_state_t s, input logic [FIB_W-1:0] maxval);
    chan_state_t      r;
    logic [FIB_W:0]   sum;
    r   = s;
    sum = {1'b0, s.prev} + {1'b0, s.cur};
    if (s.dir == DIR_RISE && sum <= {1'b0, maxval}) begin
      r.prev = s.cur;
      r.cur  = sum[FIB_W-1:0];
    end else begin
      // Overflow on the way up turns around within the same step.
      r.prev = s.cur - s.prev;
      r.cur  = s.prev;
      r.dir  = (r.prev == '0) ? DIR_RISE : DIR_FALL;
    end
    return r;
  endfunction
endpackage

// File: rtl/fib_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past each winner.
module fib_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant_oh,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    grant_oh = '0;
    win      = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        grant_oh[(int'(ptr) + k) % N] = 1'b1;
        win   = PW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= '0;
    else if (found) ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/fib_breath_scheduler.sv
// Multi-channel Fibonacci breathing PWM with one shared add/sub unit.
// Define FIB_PHASE_STAGGER_EN to offset each channel's period start by i*2**CW/NCH.
module fib_breath_scheduler
  import fib_breath_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CW   = 8,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH-1:0]    grant_oh,
  output logic [NCH*CW-1:0] duty_mon
);
  localparam int               PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int               HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]    CNT_MAX = {CW{1'b1}};
  localparam logic [FIB_W-1:0] MAXV    = FIB_W'(fib_period(CW) - 1);

  if (CW < 1 || CW >= FIB_W) begin : g_bad_cw
    $error("fib_breath_scheduler: CW out of range");
  end
  if (NCH < 1 || NCH > fib_period(CW - 1)) begin : g_bad_nch
    $error("fib_breath_scheduler: NCH out of range");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("fib_breath_scheduler: HOLD must be >= 1");
  end

  logic [NCH-1:0]         req;
  logic [PW-1:0]          rr_ptr;
  logic [NCH-1:0][CW-1:0] prev_v, cur_v;
  logic [NCH-1:0]         fall_v;
  chan_state_t            op, res;
  logic                   unused_bits;

  fib_rr_arbiter #(.N(NCH)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant_oh (grant_oh),
    .ptr      (rr_ptr)
  );

  // Operand mux into the one shared step unit; result goes back to the winner.
  always_comb begin
    op = '{prev: '0, cur: '0, dir: DIR_RISE};
    for (int i = 0; i < NCH; i++) begin
      if (grant_oh[i]) begin
        op.prev = FIB_W'(prev_v[i]);
        op.cur  = FIB_W'(cur_v[i]);
        op.dir  = fall_v[i] ? DIR_FALL : DIR_RISE;
      end
    end
    res = fib_step(op, MAXV);
  end

  assign unused_bits = ^{rr_ptr, res.prev[FIB_W-1:CW], res.cur[FIB_W-1:CW]};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] prev, cur, duty, cnt, cnt_cur;
    logic [HW-1:0] hold_cnt;
    dir_e          dir;
    logic          pwm, req_r;

`ifdef FIB_PHASE_STAGGER_EN
    localparam logic [CW-1:0] OFFS = CW'(i * (fib_period(CW) / NCH));
    logic en_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= en[i];
    end
    assign cnt_cur = (en[i] && !en_q) ? OFFS : cnt;
`else
    assign cnt_cur = cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev <= '0;  cur <= CW'(1);  dir <= DIR_RISE;  duty <= CW'(1);
        cnt <= '0;   hold_cnt <= '0; req_r <= 1'b0;    pwm <= 1'b0;
      end else if (!en[i]) begin
        // Disabled channel idles at reset values; a same-cycle grant is dropped.
        prev <= '0;  cur <= CW'(1);  dir <= DIR_RISE;  duty <= CW'(1);
        cnt <= '0;   hold_cnt <= '0; req_r <= 1'b0;    pwm <= 1'b0;
      end else begin
        pwm <= (cnt_cur < duty);
        cnt <= cnt_cur + 1'b1;
        if (grant_oh[i]) begin
          req_r <= 1'b0;
          prev  <= res.prev[CW-1:0];
          cur   <= res.cur[CW-1:0];
          dir   <= res.dir;
        end
        if (cnt_cur == CNT_MAX) begin
          duty <= cur;
          if (hold_cnt == HW'(HOLD - 1)) begin
            hold_cnt <= '0;
            req_r    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end
    end

    assign prev_v[i]              = prev;
    assign cur_v[i]               = cur;
    assign fall_v[i]              = (dir == DIR_FALL);
    assign req[i]                 = req_r;
    assign pwm_out[i]             = pwm;
    assign duty_mon[i*CW +: CW]   = duty;
  end
endmodule

// File: tb/tb_fib_breath_scheduler.sv
// Bench for fib_breath_scheduler: closed-form duty/PWM model per channel plus
// a round-robin request model, driven by directed phases and random enables.
module tb_fib_breath_scheduler;
  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int HOLD = 2;
  localparam int P    = 1 << CW;
  localparam int MAXV = P - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    en = '0;
  logic [NCH-1:0]    pwm_out, grant_oh;
  logic [NCH*CW-1:0] duty_mon;

  fib_breath_scheduler #(.NCH(NCH), .CW(CW), .HOLD(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pwm_out  (pwm_out),
    .grant_oh (grant_oh),
    .duty_mon (duty_mon)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: duty of period p is the cur value after floor((p-1)/HOLD)
  // steps around the up/down Fibonacci cycle held in seq.
  int                seq[$];
  int                up_n;
  bit                act[NCH];
  int                k[NCH];
  bit                pend[NCH];
  int                ptr;
  logic [NCH-1:0]    pwm_e;
  logic [NCH*CW-1:0] duty_e, duty_rst;

  function automatic int dutyf(input int p);
    if (p == 0) return 1;
    return seq[((p - 1) / HOLD) % seq.size()];
  endfunction

  function automatic int gnt_idx();
    int c;
    for (int j = 0; j < NCH; j++) begin
      c = (ptr + j) % NCH;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] gnt_vec();
    int g;
    g = gnt_idx();
    return (g < 0) ? '0 : NCH'(1) << g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      act[i] = 1'b0; k[i] = 0; pend[i] = 1'b0;
    end
    ptr    = 0;
    pwm_e  = '0;
    duty_e = duty_rst;
  endtask

  task automatic model_edge();
    int g;
    g = gnt_idx();
    if (g >= 0) begin
      pend[g] = 1'b0;
      ptr     = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        k[i]   = act[i] ? k[i] + 1 : 0;
        act[i] = 1'b1;
        pwm_e[i] = ((k[i] % P) < dutyf(k[i] / P));
        duty_e[i*CW +: CW] = CW'(dutyf((k[i] + 1) / P));
        if ((k[i] % P) == P - 1 && ((k[i] / P) + 1) % HOLD == 0) pend[i] = 1'b1;
      end else begin
        act[i]  = 1'b0;
        pend[i] = 1'b0;
        pwm_e[i] = 1'b0;
        duty_e[i*CW +: CW] = CW'(1);
      end
    end
  endtask

  task automatic compare_all();
    chk("pwm", 64'(pwm_out), 64'(pwm_e));
    chk("grant", 64'(grant_oh), 64'(gnt_vec()));
    chk("duty", 64'(duty_mon), 64'(duty_e));
  endtask

  bit track = 1'b0;
  int last_d = 1;
  int max_obs = 0;
  int after_peak = -1;

  task automatic tick();
    int d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (track) begin
      d = int'(duty_mon[CW-1:0]);
      if (d != last_d) begin
        if (last_d == seq[up_n-1] && after_peak < 0) after_peak = d;
        if (d > max_obs) max_obs = d;
        last_d = d;
      end
    end
  endtask

  initial begin
    int a, b, t, bit_i;
    bit dropped;

    a = 0; b = 1;
    while (b <= MAXV) begin
      seq.push_back(b);
      t = a + b; a = b; b = t;
    end
    up_n = seq.size();
    for (int j = up_n - 2; j >= 1; j--) seq.push_back(seq[j]);
    for (int j = 0; j < NCH; j++) duty_rst[j*CW +: CW] = CW'(1);
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_pwm", 64'(pwm_out), 64'(0));
    chk("rst_grant", 64'(grant_oh), 64'(0));
    chk("rst_duty", 64'(duty_mon), 64'(duty_rst));

    // Single channel long run: full climb, turnaround and recovery.
    rst_n = 1'b1;
    en    = NCH'(1);
    track = 1'b1;
    repeat (54 * P) tick();
    for (int c = 0; c < 8000 && duty_e[CW-1:0] != CW'(55); c++) tick();
    track = 1'b0;
    chk("hit_55", 64'(duty_mon[CW-1:0]), 64'(55));
    chk("peak", 64'(max_obs), 64'(seq[up_n-1]));
    chk("after_peak", 64'(after_peak), 64'(seq[up_n]));

    // Asynchronous reset in the middle of a period.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", 64'(pwm_out), 64'(0));
    chk("arst_grant", 64'(grant_oh), 64'(0));
    chk("arst_duty", 64'(duty_mon), 64'(duty_rst));
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // All channels together; channel 2 drops out while it holds the grant.
    en = '1;
    dropped = 1'b0;
    for (int c = 0; c < 3000 && !dropped; c++) begin
      if (gnt_idx() == 2) begin
        en[2]   = 1'b0;
        dropped = 1'b1;
      end
      tick();
    end
    chk("drop_seen", 64'(dropped), 64'(1));
    chk("drop_pwm2", 64'(pwm_out[2]), 64'(0));
    chk("drop_next_grant", 64'(grant_oh), 64'(4'b1000));
    repeat (600) tick();
    en[2] = 1'b1;
    repeat (900) tick();

    // Random enable traffic.
    for (int r = 0; r < 40; r++) begin
      if (r % 5 == 0) begin
        en = NCH'($urandom);
      end else begin
        bit_i = int'($urandom_range(0, NCH - 1));
        en[bit_i] = ~en[bit_i];
      end
      repeat ($urandom_range(1, 700)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
